// File: rtl/if_id_stage.sv
// IF/ID pipeline register with decode front: field extraction, immediate
// generation, PC-relative target, load-use hazard, flush squashing and HALT.
module if_id_stage #(
    parameter logic [31:0] NOP_INSTR    = 32'h00000013,
    parameter logic [6:0]  HALT_OPCODE  = 7'h7F,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_next_pc,
    input  logic        flush,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_next_pc,
    output logic        id_valid,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] imm,
    output logic [31:0] rel_target,
    output logic        stall,
    output logic        ex_bubble,
    output logic        halted
);

    localparam int unsigned CW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   id_instr_q, id_instr_d;
    logic [31:0]   id_pc_q, id_pc_d;
    logic [31:0]   id_next_pc_q, id_next_pc_d;
    logic          id_valid_q, id_valid_d;
    logic          uses_rs1, uses_rs2, hazard, halt_in_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RUN;
            cnt_q        <= '0;
            id_instr_q   <= NOP_INSTR;
            id_pc_q      <= '0;
            id_next_pc_q <= 32'd1;
            id_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            id_next_pc_q <= id_next_pc_d;
            id_valid_q   <= id_valid_d;
        end
    end

    assign id_instr   = id_instr_q;
    assign id_pc      = id_pc_q;
    assign id_next_pc = id_next_pc_q;
    assign id_valid   = id_valid_q;
    assign rs1        = id_instr_q[19:15];
    assign rs2        = id_instr_q[24:20];
    assign rd         = id_instr_q[11:7];
    assign opcode     = id_instr_q[6:0];
    assign funct3     = id_instr_q[14:12];
    assign funct7     = id_instr_q[31:25];
    assign halted     = (state_q == S_HALT);
    assign rel_target = id_pc_q + 32'($signed(imm) >>> 2);

    always_comb begin
        imm = '0;
        unique case (opcode)
            7'b0010011, 7'b0000011, 7'b1100111:
                imm = {{20{id_instr_q[31]}}, id_instr_q[31:20]};
            7'b0100011:
                imm = {{20{id_instr_q[31]}}, id_instr_q[31:25], id_instr_q[11:7]};
            7'b1100011:
                imm = {{19{id_instr_q[31]}}, id_instr_q[31], id_instr_q[7],
                       id_instr_q[30:25], id_instr_q[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm = {id_instr_q[31:12], 12'b0};
            7'b1101111:
                imm = {{11{id_instr_q[31]}}, id_instr_q[31], id_instr_q[19:12],
                       id_instr_q[20], id_instr_q[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    always_comb begin
        uses_rs1 = !(opcode == 7'b0110111 || opcode == 7'b0010111 || opcode == 7'b1101111);
        uses_rs2 = (opcode == 7'b0110011 || opcode == 7'b0100011 || opcode == 7'b1100011);
        hazard   = id_valid_q && ex_mem_read && (ex_rd != 5'd0) &&
                   ((uses_rs1 && ex_rd == rs1) || (uses_rs2 && ex_rd == rs2));
        halt_in_id = id_valid_q && (opcode == HALT_OPCODE);
    end

    // Priority: flush > halt > hazard > normal capture; HALT state ignores everything.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        id_next_pc_d = id_next_pc_q;
        id_valid_d   = id_valid_q;
        stall        = 1'b0;
        ex_bubble    = 1'b0;
        unique case (state_q)
            S_HALT: begin
                stall = 1'b1;
            end
            S_RUN, S_FLUSH: begin
                if (flush) begin
                    id_instr_d = NOP_INSTR;
                    id_valid_d = 1'b0;
                    cnt_d      = CW'(FLUSH_CYCLES - 1);
                    state_d    = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
                end else if (state_q == S_FLUSH) begin
                    id_instr_d = NOP_INSTR;
                    id_valid_d = 1'b0;
                    // Counter reaching zero on this edge means the window is spent.
                    cnt_d      = cnt_q - CW'(1);
                    if (cnt_q <= CW'(1)) begin
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end
                end else if (halt_in_id) begin
                    state_d = S_HALT;
                    stall   = 1'b1;
                end else if (hazard) begin
                    stall     = 1'b1;
                    ex_bubble = 1'b1;
                end else begin
                    id_instr_d   = if_instr;
                    id_pc_d      = if_pc;
                    id_next_pc_d = if_next_pc;
                    id_valid_d   = 1'b1;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage with hand-computed expectations.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_instr, if_pc, if_next_pc;
    logic        flush, ex_mem_read;
    logic [4:0]  ex_rd;
    logic [31:0] id_instr, id_pc, id_next_pc, imm, rel_target;
    logic        id_valid, stall, ex_bubble, halted;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_id_stage #(
        .NOP_INSTR(32'h00000013),
        .HALT_OPCODE(7'h7F),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_instr(if_instr), .if_pc(if_pc), .if_next_pc(if_next_pc),
        .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .id_instr(id_instr), .id_pc(id_pc), .id_next_pc(id_next_pc), .id_valid(id_valid),
        .rs1(rs1), .rs2(rs2), .rd(rd), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .imm(imm), .rel_target(rel_target),
        .stall(stall), .ex_bubble(ex_bubble), .halted(halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] instr, input logic [31:0] pc);
        if_instr   = instr;
        if_pc      = pc;
        if_next_pc = pc + 32'd1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
        fetch(32'h00000013, 32'd0);
        tick(); tick();
        chk("rst_instr", id_instr, 32'h00000013);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_npc", id_next_pc, 32'd1);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;

        // Normal capture: addi a0,x0,12 then jal ra,+16
        fetch(32'h00c00513, 32'd0);
        tick();
        chk("addi_instr", id_instr, 32'h00c00513);
        chk("addi_rd", {27'd0, rd}, 32'd10);
        chk("addi_imm", imm, 32'd12);
        chk("addi_valid", {31'd0, id_valid}, 32'd1);
        fetch(32'h010000ef, 32'd1);
        tick();
        chk("jal_imm", imm, 32'd16);
        chk("jal_target", rel_target, 32'd5);
        chk("jal_npc", id_next_pc, 32'd2);

        // Load-use on rs2
        fetch(32'h00b003b3, 32'd3);
        tick();
        chk("add_rs2", {27'd0, rs2}, 32'd11);
        ex_mem_read = 1'b1; ex_rd = 5'd11;
        fetch(32'h00000013, 32'd4);
        #1;
        chk("lu_stall", {31'd0, stall}, 32'd1);
        chk("lu_bubble", {31'd0, ex_bubble}, 32'd1);
        tick();
        chk("lu_hold_instr", id_instr, 32'h00b003b3);
        chk("lu_hold_pc", id_pc, 32'd3);
        ex_mem_read = 1'b0;
        #1;
        chk("lu_clear", {31'd0, stall}, 32'd0);
        ex_mem_read = 1'b1; ex_rd = 5'd0;
        #1;
        chk("lu_x0", {31'd0, stall}, 32'd0);

        // Flush concurrent with hazard: flush wins
        ex_rd = 5'd11; flush = 1'b1;
        #1;
        chk("fl_hz_stall", {31'd0, stall}, 32'd0);
        chk("fl_hz_bubble", {31'd0, ex_bubble}, 32'd0);
        fetch(32'h00051863, 32'd9);
        tick();
        flush = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
        chk("fl1_instr", id_instr, 32'h00000013);
        chk("fl1_valid", {31'd0, id_valid}, 32'd0);
        chk("fl1_pc", id_pc, 32'd3);
        tick();
        chk("fl2_instr", id_instr, 32'h00000013);
        chk("fl2_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("fl3_instr", id_instr, 32'h00051863);
        chk("bne_imm", imm, 32'd16);
        chk("bne_target", rel_target, 32'd13);

        // Second flush inside the window restarts it
        flush = 1'b1;
        tick();
        tick();
        flush = 1'b0;
        chk("refl_a", {31'd0, id_valid}, 32'd0);
        fetch(32'hfe1ff0ef, 32'd13);
        tick();
        chk("refl_b", {31'd0, id_valid}, 32'd0);
        tick();
        chk("refl_cap", id_instr, 32'hfe1ff0ef);
        chk("jneg_imm", imm, 32'hffffffe0);
        chk("jneg_target", rel_target, 32'd5);

        fetch(32'hfe62ae23, 32'd14);
        tick();
        chk("s_imm", imm, 32'hfffffffc);

        // HALT squashed by flush
        fetch(32'h0000007f, 32'd20);
        tick();
        flush = 1'b1;
        #1;
        chk("hsq_stall", {31'd0, stall}, 32'd0);
        fetch(32'h00000013, 32'd21);
        tick();
        flush = 1'b0;
        chk("hsq_halted", {31'd0, halted}, 32'd0);
        tick(); tick();
        chk("hsq_resume", id_pc, 32'd21);
        chk("hsq_halted2", {31'd0, halted}, 32'd0);

        // HALT latches and freezes
        fetch(32'h0000007f, 32'd30);
        tick();
        chk("h_stall_id", {31'd0, stall}, 32'd1);
        tick();
        chk("h_halted", {31'd0, halted}, 32'd1);
        fetch(32'h00c00513, 32'd31);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("h_hold_instr", id_instr, 32'h0000007f);
        chk("h_hold_pc", id_pc, 32'd30);
        chk("h_stall", {31'd0, stall}, 32'd1);
        chk("h_halted_held", {31'd0, halted}, 32'd1);
        chk("h_bubble", {31'd0, ex_bubble}, 32'd0);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_instr", id_instr, 32'h00000013);
        chk("ar_pc", id_pc, 32'd0);
        chk("ar_npc", id_next_pc, 32'd1);
        chk("ar_valid", {31'd0, id_valid}, 32'd0);
        chk("ar_halted", {31'd0, halted}, 32'd0);
        chk("ar_stall", {31'd0, stall}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
